// File: rtl/conv_out_requant.sv
// Small synchronous FIFO with a synchronous clear.
// Latency: a pushed word is visible at the head one cycle after the push edge.
// Backpressure: a push while full is accepted only with a pop in the same cycle.
// Ports: clk/rst_n; clr flushes; push/push_dat write; pop/pop_dat read the head;
//        not_empty/full report occupancy. pop_dat reads 0 while empty.
module conv_out_requant_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic             not_empty,
  output logic             full
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             wr_en, rd_en;

  assign not_empty = (cnt_q != '0);
  assign full      = (cnt_q == CW'(DEPTH));
  assign wr_en     = push && (!full || pop);
  assign rd_en     = pop && not_empty;
  assign pop_dat   = not_empty ? mem_q[rd_ptr_q] : '0;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (wr_en) begin
        mem_d[wr_ptr_q] = push_dat;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
      if (wr_en && !rd_en) cnt_d = cnt_q + CW'(1);
      else if (rd_en && !wr_en) cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end
endmodule

// Conv PE output stage: tile accumulation, int8 requant, 4-byte packing, output FIFO.
// Latency: final tile at edge T -> sum T, product T+1, byte/word T+2, FIFO push T+3.
// Backpressure: none toward the PE; a word arriving at a full FIFO is dropped (overflow).
// Ports: start/cfg_* load a job; din/din_valid PE results; dout/dout_valid/dout_ready/
//        dout_last packed output words; busy/done/overflow job status.
module conv_out_requant #(
  parameter int ACC_W      = 40,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [4:0]  cfg_tiles,
  input  logic [15:0] cfg_pixels,
  input  logic [15:0] cfg_mult,
  input  logic [4:0]  cfg_shift,
  input  logic        cfg_relu,
  input  logic [31:0] din,
  input  logic        din_valid,
  output logic [31:0] dout,
  output logic        dout_valid,
  input  logic        dout_ready,
  output logic        dout_last,
  output logic        busy,
  output logic        done,
  output logic        overflow
);
  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_e;

  state_e            state_q, state_d;
  logic [4:0]        cfg_tiles_q, cfg_tiles_d, cfg_shift_q, cfg_shift_d;
  logic [15:0]       cfg_pixels_q, cfg_pixels_d, cfg_mult_q, cfg_mult_d;
  logic              cfg_relu_q, cfg_relu_d;
  logic [4:0]        tile_cnt_q, tile_cnt_d;
  logic [15:0]       pix_cnt_q, pix_cnt_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic              s_vld_q, s_vld_d, s_last_q, s_last_d;
  logic [31:0]       s_q, s_d;
  logic              p_vld_q, p_vld_d, p_last_q, p_last_d;
  logic [47:0]       p_q, p_d;
  logic [1:0]        lane_q, lane_d;
  logic [31:0]       pack_q, pack_d;
  logic              push_q, push_d, push_last_q, push_last_d;
  logic [31:0]       push_dat_q, push_dat_d;
  logic              overflow_q, overflow_d;

  logic [ACC_W-1:0]  din_ext, acc_sum;
  logic [31:0]       sum_sat;
  logic [4:0]        tiles_m1;
  logic [15:0]       pix_next;
  logic              acc_en, tile_done;
  logic [47:0]       rnd, rsum;
  logic signed [47:0] rsh;
  logic [7:0]        q_byte;
  logic [31:0]       pack_new;
  logic [32:0]       fifo_dat;
  logic              fifo_full, pop;

  assign din_ext  = {{(ACC_W-32){din[31]}}, din};
  assign acc_sum  = (tile_cnt_q == 5'd0) ? din_ext : acc_q + din_ext;
  // Sum fits int32 only if every bit above bit 31 matches the sign.
  assign sum_sat  = (acc_sum[ACC_W-1:31] != {(ACC_W-31){acc_sum[ACC_W-1]}})
                    ? (acc_sum[ACC_W-1] ? 32'h8000_0000 : 32'h7FFF_FFFF)
                    : acc_sum[31:0];
  assign tiles_m1 = (cfg_tiles_q == 5'd0) ? 5'd0 : cfg_tiles_q - 5'd1;
  assign tile_done = (tile_cnt_q == tiles_m1);
  assign pix_next = pix_cnt_q + 16'd1;
  assign acc_en   = (state_q == ACCUM) && din_valid && (pix_cnt_q != cfg_pixels_q);

  // |s * mult| < 2^47, so the low 48 bits of an unsigned product are the signed result.
  assign p_d      = {{16{s_q[31]}}, s_q} * {32'd0, cfg_mult_q};
  assign rnd      = (cfg_shift_q != 5'd0) ? (48'd1 << (cfg_shift_q - 5'd1)) : 48'd0;
  assign rsum     = p_q + rnd;
  assign rsh      = $signed(rsum) >>> cfg_shift_q;

  always_comb begin
    q_byte = rsh[7:0];
    if (cfg_relu_q && rsh[47]) q_byte = 8'h00;
    else if (rsh[47:7] != {41{rsh[47]}}) q_byte = rsh[47] ? 8'h80 : 8'h7F;
  end

  assign pack_new = pack_q | (32'(q_byte) << {lane_q, 3'b000});

  assign pop        = dout_valid && dout_ready;
  assign dout_last  = fifo_dat[32];
  assign dout       = fifo_dat[31:0];
  assign busy       = (state_q != IDLE);
  assign done       = pop && dout_last && (state_q == DRAIN) && !start;
  assign overflow   = overflow_q;

  conv_out_requant_fifo #(.WIDTH(33), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (start),
    .push      (push_q),
    .push_dat  ({push_last_q, push_dat_q}),
    .pop       (pop),
    .pop_dat   (fifo_dat),
    .not_empty (dout_valid),
    .full      (fifo_full)
  );

  always_comb begin
    state_d      = state_q;
    cfg_tiles_d  = cfg_tiles_q;
    cfg_pixels_d = cfg_pixels_q;
    cfg_mult_d   = cfg_mult_q;
    cfg_shift_d  = cfg_shift_q;
    cfg_relu_d   = cfg_relu_q;
    tile_cnt_d   = tile_cnt_q;
    pix_cnt_d    = pix_cnt_q;
    acc_d        = acc_q;
    s_vld_d      = 1'b0;
    s_last_d     = s_last_q;
    s_d          = s_q;
    p_vld_d      = s_vld_q;
    p_last_d     = s_last_q;
    lane_d       = lane_q;
    pack_d       = pack_q;
    push_d       = 1'b0;
    push_dat_d   = push_dat_q;
    push_last_d  = push_last_q;
    overflow_d   = overflow_q | (push_q && fifo_full && !pop);

    if (acc_en) begin
      acc_d = acc_sum;
      if (tile_done) begin
        tile_cnt_d = 5'd0;
        pix_cnt_d  = pix_next;
        s_vld_d    = 1'b1;
        s_d        = sum_sat;
        s_last_d   = (pix_next == cfg_pixels_q);
      end else begin
        tile_cnt_d = tile_cnt_q + 5'd1;
      end
    end

    if (p_vld_q) begin
      if (lane_q == 2'd3 || p_last_q) begin
        push_d      = 1'b1;
        push_dat_d  = pack_new;
        push_last_d = p_last_q;
        pack_d      = 32'd0;
        lane_d      = 2'd0;
      end else begin
        pack_d = pack_new;
        lane_d = lane_q + 2'd1;
      end
    end

    case (state_q)
      ACCUM:   if (p_vld_q && p_last_q) state_d = DRAIN;
      DRAIN:   if (pop && dout_last) state_d = IDLE;
      default: state_d = state_q;
    endcase

    // start aborts everything in flight; the FIFO clears through its clr port.
    if (start) begin
      state_d      = ACCUM;
      cfg_tiles_d  = cfg_tiles;
      cfg_pixels_d = cfg_pixels;
      cfg_mult_d   = cfg_mult;
      cfg_shift_d  = cfg_shift;
      cfg_relu_d   = cfg_relu;
      tile_cnt_d   = 5'd0;
      pix_cnt_d    = 16'd0;
      acc_d        = '0;
      s_vld_d      = 1'b0;
      s_last_d     = 1'b0;
      p_vld_d      = 1'b0;
      p_last_d     = 1'b0;
      lane_d       = 2'd0;
      pack_d       = 32'd0;
      push_d       = 1'b0;
      push_last_d  = 1'b0;
      overflow_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cfg_tiles_q  <= '0;
      cfg_pixels_q <= '0;
      cfg_mult_q   <= '0;
      cfg_shift_q  <= '0;
      cfg_relu_q   <= 1'b0;
      tile_cnt_q   <= '0;
      pix_cnt_q    <= '0;
      acc_q        <= '0;
      s_vld_q      <= 1'b0;
      s_last_q     <= 1'b0;
      s_q          <= '0;
      p_vld_q      <= 1'b0;
      p_last_q     <= 1'b0;
      p_q          <= '0;
      lane_q       <= '0;
      pack_q       <= '0;
      push_q       <= 1'b0;
      push_dat_q   <= '0;
      push_last_q  <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cfg_tiles_q  <= cfg_tiles_d;
      cfg_pixels_q <= cfg_pixels_d;
      cfg_mult_q   <= cfg_mult_d;
      cfg_shift_q  <= cfg_shift_d;
      cfg_relu_q   <= cfg_relu_d;
      tile_cnt_q   <= tile_cnt_d;
      pix_cnt_q    <= pix_cnt_d;
      acc_q        <= acc_d;
      s_vld_q      <= s_vld_d;
      s_last_q     <= s_last_d;
      s_q          <= s_d;
      p_vld_q      <= p_vld_d;
      p_last_q     <= p_last_d;
      p_q          <= p_d;
      lane_q       <= lane_d;
      pack_q       <= pack_d;
      push_q       <= push_d;
      push_dat_q   <= push_dat_d;
      push_last_q  <= push_last_d;
      overflow_q   <= overflow_d;
    end
  end
endmodule

// File: tb/tb_conv_out_requant.sv
module tb_conv_out_requant;
  logic        clk;
  logic        rst_n;
  logic        start;
  logic [4:0]  cfg_tiles;
  logic [15:0] cfg_pixels;
  logic [15:0] cfg_mult;
  logic [4:0]  cfg_shift;
  logic        cfg_relu;
  logic [31:0] din;
  logic        din_valid;
  logic [31:0] dout;
  logic        dout_valid;
  logic        dout_ready;
  logic        dout_last;
  logic        busy;
  logic        done;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  conv_out_requant #(.ACC_W(40), .FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .cfg_tiles  (cfg_tiles),
    .cfg_pixels (cfg_pixels),
    .cfg_mult   (cfg_mult),
    .cfg_shift  (cfg_shift),
    .cfg_relu   (cfg_relu),
    .din        (din),
    .din_valid  (din_valid),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout_last  (dout_last),
    .busy       (busy),
    .done       (done),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_job(input int tiles, input int pixels, input int mult,
                         input int shift, input logic relu);
    cfg_tiles  = 5'(tiles);
    cfg_pixels = 16'(pixels);
    cfg_mult   = 16'(mult);
    cfg_shift  = 5'(shift);
    cfg_relu   = relu;
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  task automatic feed(input int d);
    din       = 32'(d);
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (dout_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check(tag, 32'(dout_valid), 32'd1);
  endtask

  task automatic pop_word(input string tag, input logic [31:0] exp_dat,
                          input logic exp_last, input logic exp_done);
    check({tag, "_dat"}, dout, exp_dat);
    check({tag, "_last"}, 32'(dout_last), 32'(exp_last));
    dout_ready = 1'b1;
    #1;
    check({tag, "_done"}, 32'(done), 32'(exp_done));
    tick();
    dout_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] w;
    rst_n = 1'b0; start = 1'b0; cfg_tiles = '0; cfg_pixels = '0; cfg_mult = '0;
    cfg_shift = '0; cfg_relu = 1'b0; din = '0; din_valid = 1'b0; dout_ready = 1'b0;
    tick();
    tick();
    check("rst_dout", dout, 32'd0);
    check("rst_dout_valid", 32'(dout_valid), 32'd0);
    check("rst_dout_last", 32'(dout_last), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    rst_n = 1'b1;
    tick();

    // Basic pack with int8 saturation; latency of three cycles after last beat.
    set_job(1, 4, 1, 0, 1'b0);
    check("t1_busy", 32'(busy), 32'd1);
    feed(5); feed(-3); feed(200); feed(-200);
    tick(); tick();
    check("t1_valid_t2", 32'(dout_valid), 32'd0);
    tick();
    check("t1_valid_t3", 32'(dout_valid), 32'd1);
    pop_word("t1", 32'h807F_FD05, 1'b1, 1'b1);
    check("t1_idle", 32'(busy), 32'd0);
    check("t1_empty", 32'(dout_valid), 32'd0);

    // Three-tile accumulation with rounding shift.
    set_job(3, 1, 1, 2, 1'b0);
    feed(100); feed(200); feed(-50);
    wait_valid("t2_wait");
    pop_word("t2", 32'h0000_003F, 1'b1, 1'b1);

    // Negative rounding, then the same job with ReLU.
    set_job(1, 2, 1, 2, 1'b0);
    feed(-5); feed(-6);
    wait_valid("t3_wait");
    pop_word("t3", 32'h0000_FFFF, 1'b1, 1'b1);
    set_job(1, 2, 1, 2, 1'b1);
    feed(-5); feed(-6);
    wait_valid("t3r_wait");
    pop_word("t3r", 32'h0000_0000, 1'b1, 1'b1);

    // int32 saturation of the tile sum.
    set_job(2, 1, 2, 31, 1'b0);
    feed(32'h7FFF_FFF0); feed(32'h0000_0100);
    wait_valid("t4_wait");
    pop_word("t4", 32'h0000_0002, 1'b1, 1'b1);

    // Overflow: five words into a four-deep FIFO with no consumer.
    set_job(1, 20, 1, 0, 1'b0);
    for (int i = 1; i <= 20; i++) feed(i);
    repeat (5) tick();
    check("t5_overflow", 32'(overflow), 32'd1);
    for (int k = 0; k < 4; k++) begin
      w = {8'(4*k+4), 8'(4*k+3), 8'(4*k+2), 8'(4*k+1)};
      pop_word($sformatf("t5_w%0d", k), w, 1'b0, 1'b0);
    end
    check("t5_empty", 32'(dout_valid), 32'd0);
    check("t5_busy", 32'(busy), 32'd1);

    // Full FIFO with a push and a pop on the same edge.
    set_job(1, 24, 1, 0, 1'b0);
    check("t6_ovf_clr", 32'(overflow), 32'd0);
    for (int i = 1; i <= 20; i++) feed(i);
    tick(); tick();
    dout_ready = 1'b1;
    tick();
    dout_ready = 1'b0;
    check("t6_no_ovf", 32'(overflow), 32'd0);
    pop_word("t6_w1", 32'h0807_0605, 1'b0, 1'b0);
    pop_word("t6_w2", 32'h0C0B_0A09, 1'b0, 1'b0);
    check("t6_w3", dout, 32'h100F_0E0D);

    // start mid-job, coincident with a pop and a din beat.
    cfg_tiles = 5'd1; cfg_pixels = 16'd1; cfg_mult = 16'd1; cfg_shift = 5'd0; cfg_relu = 1'b0;
    start = 1'b1; din = 32'd99; din_valid = 1'b1; dout_ready = 1'b1;
    #1;
    check("t7_no_done", 32'(done), 32'd0);
    tick();
    start = 1'b0; din_valid = 1'b0; dout_ready = 1'b0;
    check("t7_flushed", 32'(dout_valid), 32'd0);
    check("t7_busy", 32'(busy), 32'd1);
    feed(7);
    wait_valid("t7_wait");
    pop_word("t7", 32'h0000_0007, 1'b1, 1'b1);

    // Asynchronous reset mid-job, then a fresh job.
    set_job(1, 8, 1, 0, 1'b0);
    for (int i = 1; i <= 6; i++) feed(i);
    repeat (4) tick();
    check("t8_pre_valid", 32'(dout_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t8_rst_valid", 32'(dout_valid), 32'd0);
    check("t8_rst_busy", 32'(busy), 32'd0);
    check("t8_rst_dout", dout, 32'd0);
    #1;
    rst_n = 1'b1;
    tick();
    set_job(2, 1, 3, 1, 1'b0);
    feed(10); feed(11);
    wait_valid("t8_wait");
    pop_word("t8", 32'h0000_0020, 1'b1, 1'b1);
    check("t8_idle", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/conv_out_requant.md
# conv_out_requant

Output stage placed directly after the convolution PE. It takes the stream of signed 32-bit PE results (`din`/`din_valid`) and sums `cfg_tiles` consecutive results into one output pixel, which covers input-channel tiling. Each pixel is then requantized to int8 by integer multiply, rounding shift, optional ReLU and saturation. Four int8 pixels are packed per 32-bit word and buffered in a small FIFO, which presents them to the feature-map writeback through a valid/ready handshake.

## Interface
- `ACC_W`, 40 — internal partial-sum accumulator width.
- `FIFO_DEPTH`, 4 — output word FIFO depth (power of two, ≥2).
- `clk` in 1 — clock.
- `rst_n` in 1 — reset; asynchronous, active-low.
- `start` in 1 — one-cycle pulse. Latches all `cfg_*` inputs, clears all state including the FIFO, enters ACCUM. Aborts any job in progress.
- `cfg_tiles` in 5 — PE results per pixel, 1..16. A value of 0 is treated as 1.
- `cfg_pixels` in 16 — pixels in the job, ≥1.
- `cfg_mult` in 16 — unsigned requant multiplier.
- `cfg_shift` in 5 — right shift, 0..31.
- `cfg_relu` in 1 — clamp negative results to 0.
- `din` in 32 — signed PE result.
- `din_valid` in 1 — `din` qualifier. There is no ready back to the PE.
- `dout` out 32 — packed int8 word; lane k is bits [8k+7:8k], earliest pixel in lane 0.
- `dout_valid` out 1 — FIFO not empty.
- `dout_ready` in 1 — consumer accepts.
- `dout_last` out 1 — marks the final word of the job.
- `busy` out 1 — high while the state is not IDLE.
- `done` out 1 — one-cycle pulse when the last word is popped.
- `overflow` out 1 — sticky flag for a dropped word; cleared by `start` or reset.

## Operation
- **States:**
  - IDLE → ACCUM on `start`.
  - ACCUM → DRAIN after the final pixel's byte enters the packer.
  - DRAIN → IDLE when the word carrying `dout_last` is popped. `done` pulses in that cycle.
  - `start` in any state restarts from ACCUM.
- `din_valid` is ignored in IDLE and DRAIN.
- **Accumulate:** `tile_cnt` counts 0..cfg_tiles-1.
  - On `din_valid` with `tile_cnt`=0: `acc` = sign-extended `din`.
  - Otherwise: `acc` = `acc` + `din`.
  - When `tile_cnt` reaches cfg_tiles-1 the pixel is complete and `tile_cnt` wraps to 0.
  - On completion the sum is saturated to signed 32-bit, giving s.
- **Requant pipeline:**
  - S1: p = s × cfg_mult, 48-bit signed; `cfg_mult` is zero-extended.
  - S2: r = (p + (cfg_shift>0 ? 2^(cfg_shift-1) : 0)) >>> cfg_shift. This is an arithmetic shift, so rounding is half-up.
  - S2: if `cfg_relu` and r<0, r=0.
  - S2: saturate r to [-128, 127].
- **Pack:** bytes fill lanes 0..3. A word is pushed to the FIFO when lane 3 is filled or when the final pixel's byte arrives. Unused lanes are 0. `dout_last` is set on the word holding the final pixel.
- `pix_cnt` counts completed pixels up to `cfg_pixels`. Further `din_valid` beats after the final pixel are ignored.
- **FIFO push/pop:**
  - A pop occurs when `dout_valid` and `dout_ready` are both high.
  - A push while full with no pop in the same cycle drops the word and sets `overflow`.
  - A push while full with a pop in the same cycle is accepted.
  - `dout`/`dout_last` hold stable while `dout_valid` is high and `dout_ready` is low.

## Timing
- **Reset values:** `dout`=0, `dout_valid`=0, `dout_last`=0, `busy`=0, `done`=0, `overflow`=0. State is IDLE and all counters are 0.
- **Latency:** take the final tile of a word-completing pixel as sampled at edge T. Then:
  - `acc`/s are registered at T.
  - The product is registered at T+1.
  - The byte is computed at T+2 and the word is pushed at T+3.
  - `dout_valid` is high from T+3 if the FIFO was empty.
- **Throughput:** one `din` per cycle sustained with no bubbles.
- **Back-to-back pixels with `cfg_tiles`=1:** one byte per cycle.
- **Asynchronous reset mid-job:** immediate return to reset values. Partial words are discarded.
- **`start` coincident with `din_valid`:** the `din` beat is dropped and the new job begins on the next beat.
- **`start` coincident with a pop:** the pop completes, then the FIFO clears. `done` is not pulsed.

## Test plan
- tiles=1, mult=1, shift=0, relu=0, pixels=4; `din`=5, −3, 200, −200 in consecutive cycles → one word 0x807FFD05 with `dout_last`=1. `dout_valid` rises 3 cycles after the last beat. `done` pulses on the pop.
- tiles=3, mult=1, shift=2, pixels=1; `din`=100, 200, −50 → sum 250, (250+2)>>2=63 → 0x0000003F with last=1.
- tiles=1, mult=1, shift=2, pixels=2; `din`=−5, −6 → −1, −1 → 0x0000FFFF. The same run with relu=1 → 0x00000000.
- Saturation: tiles=2, pixels=1; `din`=0x7FFFFFF0, 0x100 → s=0x7FFFFFFF; mult=2, shift=31 → r=2 → 0x00000002.
- FIFO_DEPTH=4, `dout_ready`=0, tiles=1, pixels=20 → 5 words produced. The 5th is dropped and `overflow`=1. Then `dout_ready`=1 pops 4 words, none carries last, and `done` does not pulse.
- Full FIFO with simultaneous push and pop → no overflow and word order is preserved. Then `start` mid-job, or `rst_n` low mid-job → `dout_valid`=0 the next cycle and counters are cleared. The following job produces correct values.
